// File: rtl/song_recorder.sv
// Records key presses of a recording session into song memory as
// (note, held-cycle duration) entries, one write strobe per accepted press.
module song_recorder #(
    parameter int DEPTH     = 26,
    parameter int MIN_PRESS = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        record_enable,
    input  logic        key_on,
    input  logic [3:0]  key,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [3:0]  wr_note,
    output logic [25:0] wr_duration,
    output logic [4:0]  entry_count,
    output logic        full,
    output logic        recording
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        MEASURE,
        WRITE,
        FULL
    } state_e;

    localparam logic [25:0] MIN_LEN   = 26'(MIN_PRESS);
    localparam logic [4:0]  DEPTH_CNT = 5'(DEPTH);

    state_e      state_q, state_d;
    logic        rec_prev_q, rec_prev_d;
    logic [3:0]  note_q, note_d;
    logic [25:0] dur_q, dur_d;
    logic        pend_q, pend_d;
    logic        stop_q, stop_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [3:0]  wr_note_q, wr_note_d;
    logic [25:0] wr_dur_q, wr_dur_d;
    logic [4:0]  count_q, count_d;

    logic        pressed;
    logic        rec_rise;
    logic        long_enough;
    logic [25:0] dur_inc;

    // Outcome of one measuring cycle; shared by MEASURE and by a WRITE cycle
    // that carries a press latched on a direct key change.
    state_e      m_state;
    logic [3:0]  m_note;
    logic [25:0] m_dur;
    logic        m_pend;
    logic        m_stop;
    logic        m_load;

    assign pressed     = key_on && (key != 4'd0);
    assign rec_rise    = record_enable && !rec_prev_q;
    assign long_enough = (dur_q >= MIN_LEN);
    assign dur_inc     = (dur_q == 26'h3FFFFFF) ? dur_q : dur_q + 26'd1;

    always_comb begin
        m_state = MEASURE;
        m_note  = note_q;
        m_dur   = dur_inc;
        m_pend  = 1'b0;
        m_stop  = 1'b0;
        m_load  = 1'b0;
        if (!record_enable) begin
            m_load  = long_enough;
            m_stop  = 1'b1;
            m_state = long_enough ? WRITE : IDLE;
        end else if (!pressed) begin
            m_load  = long_enough;
            m_state = long_enough ? WRITE : WAIT_PRESS;
        end else if (key != note_q) begin
            m_load  = long_enough;
            m_note  = key;
            m_dur   = 26'd1;
            m_pend  = long_enough;
            m_state = long_enough ? WRITE : MEASURE;
        end
    end

    always_comb begin
        state_d    = state_q;
        rec_prev_d = record_enable;
        note_d     = note_q;
        dur_d      = dur_q;
        pend_d     = pend_q;
        stop_d     = stop_q;
        wr_addr_d  = wr_addr_q;
        wr_note_d  = wr_note_q;
        wr_dur_d   = wr_dur_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (rec_rise) begin
                    state_d   = WAIT_PRESS;
                    wr_addr_d = 5'd0;
                    count_d   = 5'd0;
                    pend_d    = 1'b0;
                    stop_d    = 1'b0;
                end
            end
            WAIT_PRESS: begin
                if (!record_enable) begin
                    state_d = IDLE;
                end else if (pressed) begin
                    note_d  = key;
                    dur_d   = 26'd1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                state_d = m_state;
                note_d  = m_note;
                dur_d   = m_dur;
                pend_d  = m_pend;
                stop_d  = m_stop;
                if (m_load) begin
                    wr_note_d = note_q;
                    wr_dur_d  = dur_q;
                end
            end
            WRITE: begin
                wr_addr_d = wr_addr_q + 5'd1;
                count_d   = count_q + 5'd1;
                pend_d    = 1'b0;
                stop_d    = 1'b0;
                if (count_q + 5'd1 == DEPTH_CNT) begin
                    state_d = FULL;
                end else if (stop_q) begin
                    state_d = IDLE;
                end else if (pend_q) begin
                    state_d = m_state;
                    note_d  = m_note;
                    dur_d   = m_dur;
                    pend_d  = m_pend;
                    stop_d  = m_stop;
                    if (m_load) begin
                        wr_note_d = note_q;
                        wr_dur_d  = dur_q;
                    end
                end else if (!record_enable) begin
                    state_d = IDLE;
                end else if (pressed) begin
                    note_d  = key;
                    dur_d   = 26'd1;
                    state_d = MEASURE;
                end else begin
                    state_d = WAIT_PRESS;
                end
            end
            FULL: begin
                if (!record_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rec_prev resets high so a level already present at reset release is not a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rec_prev_q <= 1'b1;
            note_q     <= 4'd0;
            dur_q      <= 26'd0;
            pend_q     <= 1'b0;
            stop_q     <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_note_q  <= 4'd0;
            wr_dur_q   <= 26'd0;
            count_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            rec_prev_q <= rec_prev_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            pend_q     <= pend_d;
            stop_q     <= stop_d;
            wr_addr_q  <= wr_addr_d;
            wr_note_q  <= wr_note_d;
            wr_dur_q   <= wr_dur_d;
            count_q    <= count_d;
        end
    end

    assign wr_en       = (state_q == WRITE);
    assign wr_addr     = wr_addr_q;
    assign wr_note     = wr_note_q;
    assign wr_duration = wr_dur_q;
    assign entry_count = count_q;
    assign full        = (count_q == DEPTH_CNT);
    assign recording   = (state_q != IDLE);

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with a shortened minimum press length.
module tb_song_recorder;

    localparam int DEPTH     = 26;
    localparam int MIN_PRESS = 10;

    logic        clk;
    logic        rst;
    logic        record_enable;
    logic        key_on;
    logic [3:0]  key;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_note;
    logic [25:0] wr_duration;
    logic [4:0]  entry_count;
    logic        full;
    logic        recording;

    song_recorder #(.DEPTH(DEPTH), .MIN_PRESS(MIN_PRESS)) dut (
        .clk          (clk),
        .rst          (rst),
        .record_enable(record_enable),
        .key_on       (key_on),
        .key          (key),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_note      (wr_note),
        .wr_duration  (wr_duration),
        .entry_count  (entry_count),
        .full         (full),
        .recording    (recording)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // {addr, note, duration}
    logic [34:0] exp_q[$];

    typedef struct {
        logic [3:0] k;
        int         hold;
        bit         exp_wr;
    } vec_t;

    vec_t vecs[7];
    int   exp_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        key    = k;
        key_on = 1'b1;
        step(hold);
        key    = 4'd0;
        key_on = 1'b0;
        step(gap);
    endtask

    task automatic start_session();
        record_enable = 1'b0;
        step(2);
        record_enable = 1'b1;
        step(1);
    endtask

    task automatic push_exp(input int addr, input logic [3:0] n, input int d);
        logic [34:0] e;
        e = {5'(addr), n, 26'(d)};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logic [34:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%0d note=%0d dur=%0d expected no write",
                         wr_addr, wr_note, wr_duration);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_note, wr_duration} !== e)
                    $display("FAIL write_data: got addr=%0d note=%0d dur=%0d expected addr=%0d note=%0d dur=%0d",
                             wr_addr, wr_note, wr_duration, e[34:30], e[29:26], e[25:0]);
                else passed++;
            end
        end
    end

    initial begin
        rst           = 1'b1;
        record_enable = 1'b0;
        key_on        = 1'b0;
        key           = 4'd0;

        vecs[0] = '{k: 4'd5,  hold: 20, exp_wr: 1'b1};
        vecs[1] = '{k: 4'd3,  hold: 5,  exp_wr: 1'b0};
        vecs[2] = '{k: 4'd9,  hold: 10, exp_wr: 1'b1};
        vecs[3] = '{k: 4'd4,  hold: 9,  exp_wr: 1'b0};
        vecs[4] = '{k: 4'd1,  hold: 1,  exp_wr: 1'b0};
        vecs[5] = '{k: 4'd0,  hold: 12, exp_wr: 1'b0};
        vecs[6] = '{k: 4'd15, hold: 13, exp_wr: 1'b1};

        step(2);
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_wr_addr", wr_addr, 5'd0);
        check("reset_entry_count", entry_count, 5'd0);
        check("reset_full", full, 1'b0);
        check("reset_recording", recording, 1'b0);
        rst = 1'b0;
        step(2);

        // Single-press vectors within one session
        start_session();
        check("session_recording", recording, 1'b1);
        exp_count = 0;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_wr) begin
                push_exp(exp_count, vecs[i].k, vecs[i].hold);
                exp_count++;
            end
            press(vecs[i].k, vecs[i].hold, 4);
            check($sformatf("vec%0d_entry_count", i), entry_count, 5'(exp_count));
            check($sformatf("vec%0d_recording", i), recording, 1'b1);
            check($sformatf("vec%0d_drained", i), exp_q.size(), 0);
        end

        // Direct key change without release
        start_session();
        check("new_session_count_clear", entry_count, 5'd0);
        push_exp(0, 4'd2, 15);
        push_exp(1, 4'd7, 12);
        key_on = 1'b1;
        key    = 4'd2;
        step(15);
        key    = 4'd7;
        step(12);
        key_on = 1'b0;
        key    = 4'd0;
        step(4);
        check("keychg_entry_count", entry_count, 5'd2);
        check("keychg_drained", exp_q.size(), 0);

        // Fill all slots, then one more press
        start_session();
        for (int i = 0; i < DEPTH; i++) begin
            push_exp(i, 4'((i % 15) + 1), 10 + (i % 3));
            press(4'((i % 15) + 1), 10 + (i % 3), 3);
        end
        check("full_flag", full, 1'b1);
        check("full_entry_count", entry_count, 5'd26);
        check("full_wr_addr", wr_addr, 5'd26);
        check("full_recording", recording, 1'b1);
        check("full_drained", exp_q.size(), 0);
        press(4'd4, 15, 4);
        check("full_ignore_count", entry_count, 5'd26);
        record_enable = 1'b0;
        step(2);
        check("idle_recording", recording, 1'b0);
        check("idle_hold_count", entry_count, 5'd26);
        check("idle_hold_full", full, 1'b1);

        // Asynchronous reset mid-press
        start_session();
        key_on = 1'b1;
        key    = 4'd6;
        step(5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wr_en", wr_en, 1'b0);
        check("async_rst_wr_addr", wr_addr, 5'd0);
        check("async_rst_wr_note", wr_note, 4'd0);
        check("async_rst_wr_duration", wr_duration, 26'd0);
        check("async_rst_entry_count", entry_count, 5'd0);
        check("async_rst_full", full, 1'b0);
        check("async_rst_recording", recording, 1'b0);
        step(2);
        rst = 1'b0;
        step(20);
        check("no_session_after_rst", recording, 1'b0);
        check("no_write_after_rst", exp_q.size(), 0);
        key_on = 1'b0;
        key    = 4'd0;

        // record_enable dropped while a long press is held
        start_session();
        push_exp(0, 4'd8, 15);
        key_on = 1'b1;
        key    = 4'd8;
        step(15);
        record_enable = 1'b0;
        step(1);
        check("stop_write_strobe", wr_en, 1'b1);
        check("stop_still_recording", recording, 1'b1);
        step(1);
        check("stop_recording_low", recording, 1'b0);
        check("stop_entry_count", entry_count, 5'd1);
        key_on = 1'b0;
        key    = 4'd0;
        step(3);
        check("stop_drained", exp_q.size(), 0);
        check("stop_no_extra_strobe", wr_en, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 Parameter DEPTH, default 26, number of song memory slots (addresses 0..DEPTH-1) SHALL be supported.
REQ-002 Parameter MIN_PRESS, default 1000000, minimum held cycles (20 ms at 50 MHz) for a press to be stored SHALL be supported.
REQ-003 Port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port record_enable  input  1  level; high = recording session active.
REQ-006 Port key_on  input  1  synchronous, user key pressed.
REQ-007 Port key  input  4  synchronous, note value of pressed key; 0 = no note.
REQ-008 Port wr_en  output  1  one-cycle write strobe to song memory.
REQ-009 Port wr_addr  output  5  memory location for current write.
REQ-010 Port wr_note  output  4  note value to store.
REQ-011 Port wr_duration  output  26  held cycles to store, same units the auto player consumes.
REQ-012 Port entry_count  output  5  number of entries stored this session.
REQ-013 Port full  output  1  high when entry_count == DEPTH.
REQ-014 Port recording  output  1  high while FSM is not IDLE.

Function
REQ-015 A press SHALL be defined as key_on==1 and key!=0 in a sampled cycle; all other combinations count as released.
REQ-016 FSM states SHALL be IDLE, WAIT_PRESS, MEASURE, WRITE, FULL.
REQ-017 IDLE -> WAIT_PRESS on record_enable rising edge; on that edge wr_addr and entry_count SHALL clear to 0 and full to 0.
REQ-018 WAIT_PRESS -> MEASURE on first pressed cycle; latch key into note register, load duration counter with 1.
REQ-019 MEASURE: each further cycle with the same pressed key SHALL increment the 26-bit duration counter, saturating at 26'h3FFFFFF (no wrap).
REQ-020 MEASURE, release observed: if duration >= MIN_PRESS -> WRITE, else discard and -> WAIT_PRESS.
REQ-021 MEASURE, pressed with different key (key change without release): close current entry as in REQ-020 and, in the same cycle, latch new key with duration 1; the new press SHALL be measured without losing a cycle.
REQ-022 WRITE: wr_en SHALL be high for exactly one cycle, the cycle after the closing event, with wr_note/wr_duration/wr_addr stable during that cycle.
REQ-023 After a write, wr_addr and entry_count SHALL increment by 1; if entry_count reaches DEPTH -> FULL, else -> WAIT_PRESS (or MEASURE if a new press was latched per REQ-021).
REQ-024 FULL: no further writes; presses ignored; full=1; wr_addr held at DEPTH-1+1 not used (wr_en stays 0).
REQ-025 record_enable falling in MEASURE SHALL close the entry per REQ-020 (write if >= MIN_PRESS), then -> IDLE; in WAIT_PRESS or FULL -> IDLE directly.
REQ-026 In IDLE, entry_count and full SHALL hold their last values so the player knows the song length; wr_en=0.
REQ-027 wr_en SHALL never assert outside WRITE; at most one write per closed press.
REQ-028 wr_addr SHALL never exceed DEPTH-1 while wr_en=1.

Reset
REQ-029 On rst high, asynchronously: state=IDLE, wr_en=0, wr_addr=0, wr_note=0, wr_duration=0, entry_count=0, full=0, recording=0.
REQ-030 rst mid-MEASURE SHALL discard the pending entry with no write strobe; record_enable already high at release of rst SHALL NOT start a session until a fresh rising edge.

Verification
REQ-031 record_enable rise, key=5 key_on=1 for 2000000 cycles, release -> one wr_en pulse, wr_addr=0, wr_note=5, wr_duration=2000000, entry_count=1.
REQ-032 Press key=3 for 500000 cycles (MIN_PRESS=1000000) -> no wr_en, entry_count unchanged, state WAIT_PRESS.
REQ-033 key=2 held 1500000 cycles then changes directly to key=7 for 1200000 cycles, release -> two pulses: (addr0,2,1500000) then (addr1,7,1200000).
REQ-034 26 valid presses -> wr_addr 0..25 in order, full=1 after 26th; 27th press -> no wr_en.
REQ-035 rst asserted 100 cycles into a 2000000-cycle press -> all outputs at reset values immediately, no wr_en; record_enable low after 1500000-cycle press -> write then recording=0.
